cache_mem_arbiter: RTL and testbench

Arbiter and sequencer for the single shared main-memory port. It serves I-cache line fills, D-cache line fills and D-cache write-through stores. The block sits between the two caches and the pipelined multi-cycle memory. For line fills it issues one word address per cycle, tags each returning word with its line index and steers it to the requesting cache. It pulses a done strobe on completion, which the caches use to release the pipeline stall.

---
 rtl/cache_mem_arbiter_pkg.sv | 21 ++
 rtl/fill_counter.sv | 35 +++
 rtl/cache_mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_mem_arbiter_pkg.sv
// Shared constants for the caches and the main-memory arbiter:
// arbiter state encodings, line geometry and fill-target encodings.
package cache_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FILL  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // 16-bit words per line, and byte-offset bits within a line
  localparam int CMA_LINE_WORDS = 8;
  localparam int CMA_OFS_W      = 4;

  typedef enum logic {
    TGT_I = 1'b0,
    TGT_D = 1'b1
  } tgt_e;

endpackage

// File: rtl/fill_counter.sv
// Word counter for a line fill: counts 0..LIMIT and holds at LIMIT,
// so the extra top bit marks "all words handled". last_o flags LIMIT-1.
module fill_counter #(
  parameter int LIMIT = 8,
  parameter int CW    = $clog2(LIMIT) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] cnt_o,
  output logic          last_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  // next count: clear wins, otherwise step until the terminal value
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && (cnt_q != CW'(LIMIT)))
      cnt_d = cnt_q + 1'b1;
  end

  // count register, synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/cache_mem_arbiter.sv
// Main-memory arbiter: fixed-priority grant between D-cache stores,
// D-cache line fills and I-cache line fills. Fills issue one word address
// per cycle and steer the pipelined returns to the owning cache.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int MEM_LAT    = 4,
  parameter int LINE_WORDS = CMA_LINE_WORDS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        I_miss_req,
  input  logic [15:0] I_miss_addr,
  input  logic        D_miss_req,
  input  logic [15:0] D_miss_addr,
  input  logic        D_wr_req,
  input  logic [15:0] D_wr_addr,
  input  logic [15:0] D_wr_data,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_data_valid,
  output logic        fill_valid,
  output logic        fill_to_D,
  output logic [2:0]  fill_word_idx,
  output logic [15:0] fill_data,
  output logic        I_fill_done,
  output logic        D_fill_done,
  output logic        D_wr_done,
  output logic        busy
);

  localparam int          CW        = $clog2(LINE_WORDS) + 1;
  localparam logic [15:0] BASE_MASK = 16'hFFFF << $clog2(2 * LINE_WORDS);
  // Latency never enters the control: completion is tracked by counting returns.
  localparam int unused_mem_lat = MEM_LAT;

  state_e        state_q, state_d;
  tgt_e          tgt_q, tgt_d;
  logic [15:0]   addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [CW-1:0] issue_cnt, recv_cnt;
  logic          recv_last, issue_last_unused;
  logic          cnt_clr, issue_act, recv_en;

  // counters restart every time the arbiter passes through IDLE
  assign cnt_clr   = (state_q == ST_IDLE);
  assign issue_act = (state_q == ST_FILL) && (issue_cnt != CW'(LINE_WORDS));
  assign recv_en   = (state_q == ST_FILL) && mem_data_valid;

  fill_counter #(.LIMIT(LINE_WORDS)) u_issue_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .en_i  (issue_act),
    .cnt_o (issue_cnt),
    .last_o(issue_last_unused)
  );

  fill_counter #(.LIMIT(LINE_WORDS)) u_recv_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .en_i  (recv_en),
    .cnt_o (recv_cnt),
    .last_o(recv_last)
  );

  // next state, request latch and all outputs; outputs held at 0 during reset
  always_comb begin
    state_d       = state_q;
    tgt_d         = tgt_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    mem_en        = 1'b0;
    mem_wr        = 1'b0;
    mem_addr      = 16'h0;
    mem_wdata     = 16'h0;
    fill_valid    = 1'b0;
    fill_to_D     = 1'b0;
    fill_word_idx = 3'h0;
    fill_data     = 16'h0;
    I_fill_done   = 1'b0;
    D_fill_done   = 1'b0;
    D_wr_done     = 1'b0;
    busy          = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (D_wr_req) begin
          state_d = ST_WRITE;
          tgt_d   = TGT_D;
          addr_d  = D_wr_addr;
          wdata_d = D_wr_data;
        end else if (D_miss_req) begin
          state_d = ST_FILL;
          tgt_d   = TGT_D;
          addr_d  = D_miss_addr & BASE_MASK;
        end else if (I_miss_req) begin
          state_d = ST_FILL;
          tgt_d   = TGT_I;
          addr_d  = I_miss_addr & BASE_MASK;
        end
      end
      ST_WRITE: begin
        state_d   = ST_IDLE;
        mem_en    = rst_n;
        mem_wr    = rst_n;
        mem_addr  = rst_n ? addr_q : 16'h0;
        mem_wdata = rst_n ? wdata_q : 16'h0;
        D_wr_done = rst_n;
        busy      = rst_n;
      end
      ST_FILL: begin
        if (recv_en && recv_last) state_d = ST_DONE;
        busy = rst_n;
        if (issue_act && rst_n) begin
          mem_en   = 1'b1;
          mem_addr = addr_q + (16'(issue_cnt) << 1);
        end
        if (recv_en && rst_n) begin
          fill_valid    = 1'b1;
          fill_to_D     = (tgt_q == TGT_D);
          fill_word_idx = 3'(recv_cnt);
          fill_data     = mem_rdata;
        end
      end
      ST_DONE: begin
        state_d     = ST_IDLE;
        busy        = rst_n;
        D_fill_done = rst_n && (tgt_q == TGT_D);
        I_fill_done = rst_n && (tgt_q == TGT_I);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state and request latch registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tgt_q   <= TGT_I;
      addr_q  <= 16'h0;
      wdata_q <= 16'h0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: a latency-MEM_LAT memory model,
// requester models that drop req after done, and expectation queues.
module tb_cache_mem_arbiter;

  localparam int MEM_LAT = 4;

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
    int          cyc;
  } exp_t;

  logic        clk, rst_n;
  logic        I_miss_req, D_miss_req, D_wr_req;
  logic [15:0] I_miss_addr, D_miss_addr, D_wr_addr, D_wr_data;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_data_valid;
  logic        fill_valid, fill_to_D;
  logic [2:0]  fill_word_idx;
  logic [15:0] fill_data;
  logic        I_fill_done, D_fill_done, D_wr_done, busy;

  int   vectors = 0, miscompares = 0;
  int   cyc = 0;
  bit   mon_en = 0, gap = 0, stray = 0;
  int   last_fill_cyc = 0, last_done_cyc = 0;
  exp_t rd_q[$], wr_q[$], fill_q[$], done_q[$], mem_q[$];

  cache_mem_arbiter #(.MEM_LAT(MEM_LAT), .LINE_WORDS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .I_miss_req(I_miss_req), .I_miss_addr(I_miss_addr),
    .D_miss_req(D_miss_req), .D_miss_addr(D_miss_addr),
    .D_wr_req(D_wr_req), .D_wr_addr(D_wr_addr), .D_wr_data(D_wr_data),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid),
    .fill_valid(fill_valid), .fill_to_D(fill_to_D),
    .fill_word_idx(fill_word_idx), .fill_data(fill_data),
    .I_fill_done(I_fill_done), .D_fill_done(D_fill_done), .D_wr_done(D_wr_done),
    .busy(busy)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [63:0] outs();
    return {5'b0, mem_en, mem_wr, mem_addr, mem_wdata, fill_valid, fill_to_D,
            fill_word_idx, fill_data, I_fill_done, D_fill_done, D_wr_done, busy};
  endfunction

  task automatic push_fill(input logic [15:0] base, input logic tgt, input int c0, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      logic [15:0] a;
      a = base + 16'(2 * i);
      rd_q.push_back('{a, 16'h0, c0 + 1 + i});
      fill_q.push_back('{{12'h0, tgt, 3'(i)}, a ^ 16'h5A5A, gaps ? -1 : c0 + 1 + MEM_LAT + i});
    end
  endtask

  task automatic push_done(input logic [2:0] code, input int c);
    done_q.push_back('{{13'h0, code}, 16'h0, c});
  endtask

  task automatic wait_drain(input string tag, input int lim);
    int n = 0;
    while ((rd_q.size() + wr_q.size() + fill_q.size() + done_q.size()) != 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_pending"}, 64'(rd_q.size() + wr_q.size() + fill_q.size() + done_q.size()), 0);
    repeat (3) @(negedge clk);
    chk({tag, "_idle_busy"}, 64'(busy), 0);
  endtask

  // memory model: reads return MEM_LAT cycles after issue, data = addr ^ 5A5A
  initial begin
    bit prev_v = 0;
    mem_data_valid = 0;
    mem_rdata = 0;
    forever begin
      @(posedge clk);
      #2;
      if (stray) begin
        mem_data_valid = 1;
        mem_rdata = 16'hDEAD;
      end else if (mem_q.size() != 0 && mem_q[0].cyc <= cyc && !(gap && prev_v)) begin
        exp_t m;
        m = mem_q.pop_front();
        mem_data_valid = 1;
        mem_rdata = m.a ^ 16'h5A5A;
      end else begin
        mem_data_valid = 0;
        mem_rdata = 0;
      end
      prev_v = mem_data_valid;
    end
  end

  // requesters drop req on the edge after seeing their done pulse
  initial begin
    logic di, dd, dw;
    forever begin
      @(negedge clk);
      di = I_fill_done; dd = D_fill_done; dw = D_wr_done;
      @(posedge clk);
      #1;
      if (di) I_miss_req = 0;
      if (dd) D_miss_req = 0;
      if (dw) D_wr_req = 0;
    end
  end

  // monitor: record issued reads for the memory, compare against scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mem_en && !mem_wr) mem_q.push_back('{mem_addr, 16'h0, cyc + MEM_LAT});
      if (mon_en) begin
        if (mem_en && !mem_wr) begin
          if (rd_q.size() == 0) chk("rd_extra", 64'(mem_en), 0);
          else begin
            e = rd_q.pop_front();
            chk("rd_addr", 64'(mem_addr), 64'(e.a));
            if (e.cyc >= 0) chk("rd_cyc", 64'(cyc), 64'(e.cyc));
          end
        end
        if (mem_en && mem_wr) begin
          if (wr_q.size() == 0) chk("wr_extra", 64'(mem_wr), 0);
          else begin
            e = wr_q.pop_front();
            chk("wr_addr", 64'(mem_addr), 64'(e.a));
            chk("wr_data", 64'(mem_wdata), 64'(e.d));
            if (e.cyc >= 0) chk("wr_cyc", 64'(cyc), 64'(e.cyc));
          end
        end
        if (fill_valid) begin
          last_fill_cyc = cyc;
          if (fill_q.size() == 0) chk("fill_extra", 64'(fill_valid), 0);
          else begin
            e = fill_q.pop_front();
            chk("fill_tgt_idx", {48'h0, 12'h0, fill_to_D, fill_word_idx}, 64'(e.a));
            chk("fill_data", 64'(fill_data), 64'(e.d));
            if (e.cyc >= 0) chk("fill_cyc", 64'(cyc), 64'(e.cyc));
          end
        end
        if (I_fill_done || D_fill_done || D_wr_done) begin
          last_done_cyc = cyc;
          if (done_q.size() == 0) chk("done_extra", {61'h0, D_wr_done, D_fill_done, I_fill_done}, 0);
          else begin
            e = done_q.pop_front();
            chk("done_code", {61'h0, D_wr_done, D_fill_done, I_fill_done}, 64'(e.a));
            if (e.cyc >= 0) chk("done_cyc", 64'(cyc), 64'(e.cyc));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    rst_n = 0;
    I_miss_req = 0; D_miss_req = 0; D_wr_req = 0;
    I_miss_addr = 0; D_miss_addr = 0; D_wr_addr = 0; D_wr_data = 0;

    // reset with an I miss already pending; first cycle after release still quiet
    I_miss_req = 1; I_miss_addr = 16'h1236;
    repeat (3) @(posedge clk);
    @(negedge clk) chk("rst_hold", outs(), 0);
    @(posedge clk); #1;
    rst_n = 1; c0 = cyc;
    push_fill(16'h1230, 1'b0, c0, 0);
    push_done(3'b001, c0 + 13);
    mon_en = 1;
    @(negedge clk) chk("rst_first", outs(), 0);
    @(negedge clk) chk("fill_busy", 64'(busy), 1);
    wait_drain("single_i", 60);

    // reset in the middle of a fill; stale returns must be dropped
    mon_en = 0;
    @(posedge clk); #1;
    I_miss_addr = 16'h2000; I_miss_req = 1;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 0; I_miss_req = 0;
    @(negedge clk) chk("rst_mid_hold", outs(), 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk) chk("rst_mid_after", outs(), 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("stale_fill_valid", 64'(fill_valid), 0);
    end
    chk("stale_mem_drained", 64'(mem_q.size()), 0);
    mon_en = 1;

    // simultaneous D and I misses: D first, I arbitrated after D's DONE
    @(posedge clk); #1;
    D_miss_addr = 16'h4000; I_miss_addr = 16'h0020;
    D_miss_req = 1; I_miss_req = 1; c0 = cyc;
    push_fill(16'h4000, 1'b1, c0, 0);
    push_done(3'b010, c0 + 13);
    push_fill(16'h0020, 1'b0, c0 + 14, 0);
    push_done(3'b001, c0 + 27);
    wait_drain("d_then_i", 80);

    // store wins over a pending I miss
    @(posedge clk); #1;
    D_wr_addr = 16'h00A4; D_wr_data = 16'hBEEF; I_miss_addr = 16'h0300;
    D_wr_req = 1; I_miss_req = 1; c0 = cyc;
    wr_q.push_back('{16'h00A4, 16'hBEEF, c0 + 1});
    push_done(3'b100, c0 + 1);
    push_fill(16'h0300, 1'b0, c0 + 2, 0);
    push_done(3'b001, c0 + 15);
    wait_drain("wr_then_i", 60);

    // stray valid in IDLE is ignored and does not advance the word index
    @(posedge clk); #1;
    stray = 1;
    @(negedge clk);
    chk("stray_fill_valid", 64'(fill_valid), 0);
    chk("stray_busy", 64'(busy), 0);
    @(posedge clk); #1;
    stray = 0;
    @(posedge clk); #1;
    I_miss_addr = 16'h0104; I_miss_req = 1; c0 = cyc;
    push_fill(16'h0100, 1'b0, c0, 0);
    push_done(3'b001, c0 + 13);
    wait_drain("after_stray", 60);

    // returns with gaps: words in order, done right after the 8th word
    gap = 1;
    @(posedge clk); #1;
    D_miss_addr = 16'h8ABC; D_miss_req = 1; c0 = cyc;
    push_fill(16'h8AB0, 1'b1, c0, 1);
    push_done(3'b010, -1);
    wait_drain("gaps", 80);
    chk("gap_last_word", 64'(last_fill_cyc - c0), 19);
    chk("gap_done_follow", 64'(last_done_cyc), 64'(last_fill_cyc + 1));
    gap = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
